regfile_2r1w: RTL and testbench

REGFILE_2R1W -- requirements
Module: regfile_2r1w

---
 rtl/regfile_2r1w.sv | 130 +++++++++++++
 tb/tb_regfile_2r1w.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
//   Register file with two independent read ports and one write port.
//   Reads are registered: one cycle latency with a per-port valid strobe.
//   A write and a read to the same in-range address at the same edge return
//   the new data (write-through bypass). Out-of-range reads return 0.
//
// Parameters
//   WIDTH   : data width (1..32)
//   DEPTH   : number of registers (2..32, any value)
//   ZERO_R0 : 1 -> register 0 is hard-wired to zero
//
// Ports
//   clk               : clock, all state updates on rising edge
//   reset             : synchronous active-high reset (registers, read outputs)
//   clr               : synchronous clear of all registers
//   we/waddr/wdata    : write port
//   re_a/raddr_a      : read request, port A
//   rdata_a/rvalid_a  : registered read data and valid, port A
//   re_b/raddr_b      : read request, port B
//   rdata_b/rvalid_b  : registered read data and valid, port B
// ---------------------------------------------------------------------------
module regfile_2r1w #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int ZERO_R0 = 0,
  localparam int AW     = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rvalid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_b
);

  // One extra bit so DEPTH itself fits when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_waddr_ok;
  logic             w_wr_en;
  logic [DEPTH-1:0] w_wsel;

  // A write is effective only when in range, not targeting a hard-wired
  // zero register, and not overridden by a clear in the same cycle.
  assign w_waddr_ok = ({1'b0, waddr} < DEPTH_C) && !((ZERO_R0 != 0) && (waddr == '0));
  assign w_wr_en    = we && !clr && w_waddr_ok;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wsel
      assign w_wsel[gi] = w_wr_en && (waddr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wsel[i]) r_mem[i] <= wdata;
      end
    end
  end

  // Read ports: identical logic instantiated twice.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [AW-1:0]    w_raddr;
      logic             w_re;
      logic             w_readable;
      logic [WIDTH-1:0] w_mem_rd;
      logic [WIDTH-1:0] w_next;
      logic [WIDTH-1:0] r_rdata;
      logic             r_rvalid;

      assign w_raddr = (gi == 0) ? raddr_a : raddr_b;
      assign w_re    = (gi == 0) ? re_a : re_b;

      assign w_readable = ({1'b0, w_raddr} < DEPTH_C) &&
                          !((ZERO_R0 != 0) && (w_raddr == '0));

      // Explicit decode keeps non-power-of-two depths free of
      // out-of-bounds array indexing.
      always_comb begin
        w_mem_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (w_raddr == AW'(i)) w_mem_rd = r_mem[i];
        end
      end

      // w_wr_en already excludes clr, so a read coincident with a clear
      // sees the pre-clear contents rather than bypassed write data.
      always_comb begin
        if (!w_readable)
          w_next = '0;
        else if (w_wr_en && (waddr == w_raddr))
          w_next = wdata;
        else
          w_next = w_mem_rd;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_re;
          if (w_re) r_rdata <= w_next;
        end
      end
    end
  endgenerate

  assign rdata_a  = g_port[0].r_rdata;
  assign rvalid_a = g_port[0].r_rvalid;
  assign rdata_b  = g_port[1].r_rdata;
  assign rvalid_b = g_port[1].r_rvalid;

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: default parameters (WIDTH=4, DEPTH=4)
  logic       reset1 = 1'b1, clr1 = 1'b0, we1 = 1'b0, re_a1 = 1'b0, re_b1 = 1'b0;
  logic [1:0] waddr1 = '0, raddr_a1 = '0, raddr_b1 = '0;
  logic [3:0] wdata1 = '0;
  logic [3:0] rdata_a1, rdata_b1;
  logic       rvalid_a1, rvalid_b1;

  regfile_2r1w dut1 (
    .clk(clk), .reset(reset1), .clr(clr1), .we(we1), .waddr(waddr1), .wdata(wdata1),
    .re_a(re_a1), .raddr_a(raddr_a1), .rdata_a(rdata_a1), .rvalid_a(rvalid_a1),
    .re_b(re_b1), .raddr_b(raddr_b1), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1)
  );

  // DUT 2: WIDTH=8, DEPTH=5, ZERO_R0=1
  logic       reset2 = 1'b1, clr2 = 1'b0, we2 = 1'b0, re_a2 = 1'b0, re_b2 = 1'b0;
  logic [2:0] waddr2 = '0, raddr_a2 = '0, raddr_b2 = '0;
  logic [7:0] wdata2 = '0;
  logic [7:0] rdata_a2, rdata_b2;
  logic       rvalid_a2, rvalid_b2;

  regfile_2r1w #(.WIDTH(8), .DEPTH(5), .ZERO_R0(1)) dut2 (
    .clk(clk), .reset(reset2), .clr(clr2), .we(we2), .waddr(waddr2), .wdata(wdata2),
    .re_a(re_a2), .raddr_a(raddr_a2), .rdata_a(rdata_a2), .rvalid_a(rvalid_a2),
    .re_b(re_b2), .raddr_b(raddr_b2), .rdata_b(rdata_b2), .rvalid_b(rvalid_b2)
  );

  typedef struct {
    int         cyc;
    int         port;   // 0=dut1 A, 1=dut1 B, 2=dut2 A, 3=dut2 B
    logic       v;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   cnt = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] hold [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

  always @(posedge clk) cnt <= cnt + 1;

  // Monitor: every output sample is compared against the scoreboard entry
  // targeted at the current cycle.
  always @(negedge clk) begin
    logic       av [4];
    logic [7:0] ad [4];
    exp_t       e;
    av[0] = rvalid_a1; ad[0] = {4'h0, rdata_a1};
    av[1] = rvalid_b1; ad[1] = {4'h0, rdata_b1};
    av[2] = rvalid_a2; ad[2] = rdata_a2;
    av[3] = rvalid_b2; ad[3] = rdata_b2;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cnt) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cnt || av[e.port] !== e.v || ad[e.port] !== e.d) begin
        errors++;
        $display("FAIL port%0d cyc%0d: got v=%0b d=%h, expected v=%0b d=%h (due cyc%0d)",
                 e.port, cnt, av[e.port], ad[e.port], e.v, e.d, e.cyc);
      end else begin
        $display("ok   port%0d cyc%0d: v=%0b d=%h", e.port, cnt, av[e.port], ad[e.port]);
      end
    end
  end

  function automatic void push(input int port, input logic rst, input logic re, input logic [7:0] ed);
    exp_t e;
    e.cyc  = cnt + 1;
    e.port = port;
    if (rst) begin
      e.v = 1'b0; e.d = 8'h00; hold[port] = 8'h00;
    end else if (re) begin
      e.v = 1'b1; e.d = ed; hold[port] = ed;
    end else begin
      e.v = 1'b0; e.d = hold[port];
    end
    exp_q.push_back(e);
  endfunction

  // One cycle on DUT 1 with hand-computed expected read data.
  task automatic c1(input logic rst, input logic clr, input logic we, input int wa, input int wd,
                    input logic ra, input int aa, input int ea,
                    input logic rb, input int ab, input int eb);
    @(posedge clk); #1;
    reset1 = rst; clr1 = clr; we1 = we; waddr1 = 2'(wa); wdata1 = 4'(wd);
    re_a1 = ra; raddr_a1 = 2'(aa); re_b1 = rb; raddr_b1 = 2'(ab);
    push(0, rst, ra, 8'(ea));
    push(1, rst, rb, 8'(eb));
  endtask

  task automatic c2(input logic rst, input logic we, input int wa, input int wd,
                    input logic ra, input int aa, input int ea,
                    input logic rb, input int ab, input int eb);
    @(posedge clk); #1;
    reset2 = rst; clr2 = 1'b0; we2 = we; waddr2 = 3'(wa); wdata2 = 8'(wd);
    re_a2 = ra; raddr_a2 = 3'(aa); re_b2 = rb; raddr_b2 = 3'(ab);
    push(2, rst, ra, 8'(ea));
    push(3, rst, rb, 8'(eb));
  endtask

  initial begin
    // ---------------- DUT 1 ----------------
    //  rst clr we wa wd    ra aa ea     rb ab eb
    c1(1, 0, 0, 0, 0,      0, 0, 0,     0, 0, 0);
    c1(1, 0, 1, 1, 4'hF,   1, 1, 0,     1, 1, 0);   // inputs ignored in reset
    // basic write then read, then hold
    c1(0, 0, 1, 1, 4'hA,   0, 0, 0,     0, 0, 0);
    c1(0, 0, 0, 0, 0,      1, 1, 4'hA,  0, 0, 0);
    c1(0, 0, 0, 0, 0,      0, 2, 0,     0, 0, 0);   // rdata_a holds 0xA
    c1(0, 0, 0, 0, 0,      0, 0, 0,     0, 0, 0);
    // bypass on both ports
    c1(0, 0, 1, 2, 4'h3,   0, 0, 0,     0, 0, 0);
    c1(0, 0, 1, 2, 4'h5,   1, 2, 4'h5,  1, 2, 4'h5);
    c1(0, 0, 1, 3, 4'h6,   1, 2, 4'h5,  1, 1, 4'hA); // read independent of unrelated write
    // dual port
    c1(0, 0, 1, 0, 4'h1,   0, 0, 0,     0, 0, 0);
    c1(0, 0, 1, 3, 4'hF,   0, 0, 0,     0, 0, 0);
    c1(0, 0, 0, 0, 0,      1, 0, 4'h1,  1, 3, 4'hF);
    c1(0, 0, 0, 0, 0,      1, 3, 4'hF,  1, 3, 4'hF); // same address both ports
    // fill, then clear with a coincident write and read
    c1(0, 0, 1, 0, 4'h1,   0, 0, 0,     0, 0, 0);
    c1(0, 0, 1, 1, 4'h2,   0, 0, 0,     0, 0, 0);
    c1(0, 0, 1, 2, 4'h3,   0, 0, 0,     0, 0, 0);
    c1(0, 0, 1, 3, 4'h4,   1, 3, 4'h4,  0, 0, 0);
    c1(0, 1, 1, 1, 4'h9,   1, 1, 4'h2,  1, 2, 4'h3); // pre-clear content, no bypass
    c1(0, 0, 0, 0, 0,      1, 0, 0,     1, 1, 0);
    c1(0, 0, 0, 0, 0,      1, 2, 0,     1, 3, 0);
    // refill, then reset mid-stream
    c1(0, 0, 1, 1, 4'h7,   0, 0, 0,     0, 0, 0);
    c1(0, 0, 1, 2, 4'h6,   1, 1, 4'h7,  0, 0, 0);
    c1(1, 0, 1, 3, 4'h5,   1, 1, 0,     1, 2, 0);   // no rvalid from reset cycle
    c1(0, 0, 1, 2, 4'hC,   1, 2, 4'hC,  1, 1, 0);   // first cycle after reset
    c1(0, 0, 0, 0, 0,      1, 3, 0,     1, 0, 0);
    c1(0, 0, 0, 0, 0,      1, 2, 4'hC,  0, 0, 0);
    c1(0, 0, 0, 0, 0,      0, 0, 0,     0, 0, 0);
    c1(0, 0, 0, 0, 0,      0, 0, 0,     0, 0, 0);

    // ---------------- DUT 2 (WIDTH=8, DEPTH=5, ZERO_R0=1) ----------------
    //  rst we wa wd     ra aa ea     rb ab eb
    c2(1, 0, 0, 0,      0, 0, 0,     0, 0, 0);
    c2(0, 1, 1, 8'h5A,  0, 0, 0,     0, 0, 0);
    c2(0, 1, 0, 8'hFF,  0, 0, 0,     0, 0, 0);
    c2(0, 1, 4, 8'hFF,  0, 0, 0,     0, 0, 0);
    c2(0, 1, 6, 8'hFF,  0, 0, 0,     0, 0, 0);
    c2(0, 0, 0, 0,      1, 0, 8'h00, 1, 4, 8'hFF);
    c2(0, 0, 0, 0,      1, 6, 8'h00, 1, 1, 8'h5A);
    c2(0, 1, 0, 8'h33,  1, 0, 8'h00, 1, 5, 8'h00);  // no bypass to r0; addr 5 out of range
    c2(0, 1, 6, 8'h11,  1, 6, 8'h00, 1, 2, 8'h00);  // no bypass out of range
    c2(0, 0, 0, 0,      1, 3, 8'h00, 1, 4, 8'hFF);
    c2(0, 0, 0, 0,      0, 0, 0,     0, 0, 0);
    c2(0, 0, 0, 0,      0, 0, 0,     0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
